muldiv_unit: RTL and testbench

- Iterative, multi-cycle RV32M multiply/divide unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation through a valid/ready handshake and returns the result through a valid/ready handshake after a fixed iteration count.
- Width-parametrised; uses one shared shift-add / restoring-subtract datapath.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_sign_fix.sv | 64 ++++++
 rtl/muldiv_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared operation/state encodings and helpers for the RV32M
//            multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
// ============================================================================
// Module   : muldiv_sign_fix
// Purpose  : Operand magnitudes and result-negate flags derived from the
//            RV32M opcode and operand signs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] abs1,
    output logic [DATA_WIDTH-1:0] abs2,
    output logic                  neg_q,
    output logic                  neg_r,
    output logic                  neg_p
);

    logic w_signed1;
    logic w_signed2;
    logic w_sign1;
    logic w_sign2;

    always_comb begin
        w_signed1 = 1'b0;
        w_signed2 = 1'b0;
        case (muldiv_op_e'(op))
            OP_MULH: begin
                w_signed1 = 1'b1;
                w_signed2 = 1'b1;
            end
            OP_MULHSU: begin
                w_signed1 = 1'b1;
            end
            OP_DIV, OP_REM: begin
                w_signed1 = 1'b1;
                w_signed2 = 1'b1;
            end
            default: begin
                w_signed1 = 1'b0;
                w_signed2 = 1'b0;
            end
        endcase
    end

    assign w_sign1 = w_signed1 & op1[DATA_WIDTH-1];
    assign w_sign2 = w_signed2 & op2[DATA_WIDTH-1];

    // The most-negative value maps onto itself, which is the correct unsigned magnitude.
    assign abs1  = w_sign1 ? -op1 : op1;
    assign abs2  = w_sign2 ? -op2 : op2;

    assign neg_p = ~is_div(op) & (w_sign1 ^ w_sign2);
    assign neg_q =  is_div(op) & (w_sign1 ^ w_sign2);
    assign neg_r =  is_div(op) & w_sign1;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit, one bit per cycle on a
//            shared shift-add / restoring-subtract datapath.
// Options  : MULDIV_FAST_SPECIAL_EN - finish divide-by-zero, signed overflow
//            and zero-operand multiplies directly at accept.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_cnt_load = CNT_WIDTH'(W - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    muldiv_op_e           r_op;
    logic [W-1:0]         r_hi;
    logic [W-1:0]         r_lo;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_result;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_neg_p;
    logic                 r_div_zero;

    logic [W-1:0]         w_abs1;
    logic [W-1:0]         w_abs2;
    logic                 w_neg_q;
    logic                 w_neg_r;
    logic                 w_neg_p;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_is_div;
    logic [W:0]           w_add_a;
    logic [W:0]           w_add_b;
    logic [W+1:0]         w_sum;
    logic [W-1:0]         w_hi_nxt;
    logic [W-1:0]         w_lo_nxt;
    logic [2*W-1:0]       w_prod;
    logic [2*W-1:0]       w_prod_fix;
    logic [W-1:0]         w_quo;
    logic [W-1:0]         w_rem;
    logic [W-1:0]         w_final;

    muldiv_sign_fix #(
        .DATA_WIDTH (W)
    ) u_sign_fix (
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .abs1  (w_abs1),
        .abs2  (w_abs2),
        .neg_q (w_neg_q),
        .neg_r (w_neg_r),
        .neg_p (w_neg_p)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign w_accept  = in_ready & in_valid & ~kill;
    assign w_last    = (r_cnt == '0);

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam logic [W-1:0] c_min_neg = {1'b1, {(W-1){1'b0}}};

    logic         w_special;
    logic [W-1:0] w_special_val;

    always_comb begin
        w_special     = 1'b0;
        w_special_val = '0;
        if (is_div(op)) begin
            if (op2 == '0) begin
                w_special     = 1'b1;
                w_special_val = op[1] ? op1 : '1;
            end else if (!op[0] && (op1 == c_min_neg) && (op2 == '1)) begin
                w_special     = 1'b1;
                w_special_val = op[1] ? '0 : op1;
            end
        end else if ((op1 == '0) || (op2 == '0)) begin
            w_special = 1'b1;
        end
    end
`endif

    // Multiply adds the multiplicand into the high half; divide subtracts the
    // divisor from the partial remainder (carry out set means no borrow).
    assign w_is_div = is_div(r_op);
    assign w_add_a  = w_is_div ? {r_hi, r_lo[W-1]} : {1'b0, r_hi};
    assign w_add_b  = w_is_div ? ~{1'b0, r_b}      : {1'b0, r_b};
    assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(W+1){1'b0}}, w_is_div};

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (w_is_div) begin
            w_lo_nxt = {r_lo[W-2:0], w_sum[W+1]};
            w_hi_nxt = w_sum[W+1] ? w_sum[W-1:0] : {r_hi[W-2:0], r_lo[W-1]};
        end else if (r_lo[0]) begin
            {w_hi_nxt, w_lo_nxt} = {w_sum[W:0], r_lo[W-1:1]};
        end else begin
            {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[W-1:1]};
        end
    end

    assign w_prod     = {w_hi_nxt, w_lo_nxt};
    assign w_prod_fix = r_neg_p ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    assign w_rem      = r_neg_r ? -w_hi_nxt : w_hi_nxt;

    // Signed overflow and remainder-by-zero fall out of the magnitude
    // arithmetic; only the signed quotient-by-zero needs forcing.
    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              w_final = r_div_zero ? '1 : w_quo;
            OP_REM, OP_REMU:              w_final = w_rem;
            default:                      w_final = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MULDIV_FAST_SPECIAL_EN
                    w_state_nxt = w_special ? DONE : CALC;
`else
                    w_state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (kill) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (kill || out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op       <= OP_MUL;
            r_hi       <= '0;
            r_lo       <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_neg_p    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= muldiv_op_e'(op);
                        r_hi       <= '0;
                        r_lo       <= w_abs1;
                        r_b        <= w_abs2;
                        r_neg_q    <= w_neg_q;
                        r_neg_r    <= w_neg_r;
                        r_neg_p    <= w_neg_p;
                        r_div_zero <= (op2 == '0);
                        r_cnt      <= c_cnt_load;
`ifdef MULDIV_FAST_SPECIAL_EN
                        if (w_special) begin
                            r_result <= w_special_val;
                        end
`endif
                    end
                end
                CALC: begin
                    if (!kill) begin
                        r_hi <= w_hi_nxt;
                        r_lo <= w_lo_nxt;
                        if (w_last) begin
                            r_result <= w_final;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int c_lat = 32;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int c_special_lat = 1;
`else
    localparam int c_special_lat = 32;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          n_assert;
    int          n_fail;
    logic [31:0] last_exp;

    muldiv_unit #(
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int   lat;
        logic got;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        op1      = a;
        op2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        lat      = 0;
        got      = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1'b1;
        end
        if (!got) check({tag, "_timeout"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check({tag, "_hold_res"}, result, exp);
            check({tag, "_hold_iready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_ovalid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        last_exp  = exp;
    endtask

    initial begin
        int seen;
        n_assert  = 0;
        n_fail    = 0;
        last_exp  = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        op1       = '0;
        op2       = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, c_lat, 5);
        run_op("mulh",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, c_lat, 0);
        run_op("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, c_lat, 0);
        run_op("mulhu",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, c_lat, 0);
        run_op("mulzero", OP_MUL,    32'd0,          32'h0000_1234, 32'd0,         c_special_lat, 0);
        run_op("div",     OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, c_lat, 0);
        run_op("rem",     OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, c_lat, 0);
        run_op("remu",    OP_REMU,   32'd10,         32'd3,         32'd1,         c_lat, 0);
        run_op("div0",    OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, c_special_lat, 0);
        run_op("divneg0", OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, c_special_lat, 0);
        run_op("remu0",   OP_REMU,   32'd5,          32'd0,         32'd5,         c_special_lat, 0);
        run_op("divovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, c_special_lat, 0);
        run_op("removf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         c_special_lat, 0);
        run_op("divu",    OP_DIVU,   32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, c_lat, 0);

        // Abort a divide ten cycles in.
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_DIV;
        op1      = 32'd100;
        op2      = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ovalid", 32'(out_valid), 32'd0);
        check("kill_iready", 32'(in_ready), 32'd1);
        check("kill_result", result, last_exp);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("kill_no_valid", 32'(seen), 32'd0);

        // Kill beats a request presented in IDLE.
        @(negedge clk);
        in_valid = 1'b1;
        kill     = 1'b1;
        op       = OP_MUL;
        op1      = 32'd9;
        op2      = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_idle_iready", 32'(in_ready), 32'd1);

        run_op("mul_after_kill", OP_MUL, 32'd3, 32'd4, 32'd12, c_lat, 0);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_MUL;
        op1      = 32'd5;
        op2      = 32'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ovalid", 32'(out_valid), 32'd0);
        check("arst_iready", 32'(in_ready), 32'd1);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, c_lat, 0);
        run_op("remu_after_rst", OP_REMU, 32'd100, 32'd7, 32'd2,  c_lat, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
